// File: rtl/gpio_disp_pkg.sv
// Shared definitions for the multi-digit GPIO display: display modes,
// the active-high seven-segment glyph table and the per-digit encoder.
package gpio_disp_pkg;

    typedef enum logic [1:0] {
        MODE_HEX   = 2'd0,
        MODE_BCD   = 2'd1,
        MODE_BLANK = 2'd2,
        MODE_LAMP  = 2'd3
    } mode_e;

    // Segment patterns are active-high here; the top level applies board polarity.
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ALL   = 7'h7F;

    // Bit order gfedcba, glyphs 0-9 and A b C d E F.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Active-high segment pattern for one nibble in the given display mode.
    function automatic logic [6:0] seg_encode(input logic [3:0] nibble, input mode_e mode);
        logic [6:0] seg;
        case (mode)
            MODE_HEX:   seg = GLYPH_TABLE[nibble];
            MODE_BCD:   seg = (nibble <= 4'd9) ? GLYPH_TABLE[nibble] : SEG_BLANK;
            MODE_BLANK: seg = SEG_BLANK;
            default:    seg = SEG_ALL;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/gpio_multi_digit_display_debounce.sv
// One GPIO channel: two-flop synchroniser followed by a saturating
// debounce counter. A value is accepted only after it has been seen
// unchanged at the synchroniser output for DEBOUNCE_CYC further edges.
module gpio_debounce_ch #(
    parameter int W            = 4,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q_accepted,
    output logic         change_pulse,
    output logic         stable
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [W-1:0]     sync1_reg;
    logic [W-1:0]     sync2_reg;
    logic [W-1:0]     candidate_reg;
    logic [W-1:0]     accepted_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             pulse_reg;
    logic             stable_reg;

    // Plain two-flop synchroniser; nothing may sit between the stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= d;
            sync2_reg <= sync1_reg;
        end
    end

    // Restart on any change, count up while held, accept once saturated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            candidate_reg <= '0;
            accepted_reg  <= '0;
            cnt_reg       <= '0;
            pulse_reg     <= 1'b0;
            stable_reg    <= 1'b0;
        end else begin
            pulse_reg <= 1'b0;
            if (sync2_reg != candidate_reg) begin
                candidate_reg <= sync2_reg;
                cnt_reg       <= '0;
                stable_reg    <= 1'b0;
            end else if (cnt_reg < CNT_MAX) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else begin
                // Saturated: the counter holds here until the input moves again.
                stable_reg <= 1'b1;
                if (accepted_reg != candidate_reg) begin
                    accepted_reg <= candidate_reg;
                    pulse_reg    <= 1'b1;
                end
            end
        end
    end

    assign q_accepted   = accepted_reg;
    assign change_pulse = pulse_reg;
    assign stable       = stable_reg;

endmodule

// File: rtl/gpio_multi_digit_display.sv
// Multi-channel GPIO nibble capture driving one seven-segment digit per
// channel plus a thermometer LED bar of channel 0. Each channel is
// debounced independently; display outputs are registered from the
// accepted values and the current mode.
module gpio_multi_digit_display
    import gpio_disp_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int LED_W        = 10,
    parameter int SEG_ACT_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH*4-1:0]   gpio_in,
    input  logic [1:0]            mode,
    output logic [NUM_CH*7-1:0]   hex_out,
    output logic [LED_W-1:0]      ledr,
    output logic [NUM_CH-1:0]     change_pulse,
    output logic [NUM_CH-1:0]     stable
);

    // All segments dark, expressed in board polarity.
    localparam logic [6:0]          DIGIT_OFF = (SEG_ACT_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
    localparam logic [NUM_CH*7-1:0] HEX_OFF   = {NUM_CH{DIGIT_OFF}};

    logic [NUM_CH*4-1:0] accepted;
    logic [NUM_CH*7-1:0] hex_next;
    logic [NUM_CH*7-1:0] hex_reg;
    logic [LED_W-1:0]    led_next;
    logic [LED_W-1:0]    ledr_reg;

    // Per-channel debounce and segment encoding.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [6:0] seg;

        gpio_debounce_ch #(
            .W            (4),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .clk          (clk),
            .reset        (reset),
            .d            (gpio_in[4*gi +: 4]),
            .q_accepted   (accepted[4*gi +: 4]),
            .change_pulse (change_pulse[gi]),
            .stable       (stable[gi])
        );

        assign seg                  = seg_encode(accepted[4*gi +: 4], mode_e'(mode));
        assign hex_next[7*gi +: 7]  = (SEG_ACT_LOW != 0) ? ~seg : seg;
    end

    // Thermometer bar: LED i lights when the channel-0 value exceeds i,
    // which naturally saturates once the value reaches LED_W.
    for (genvar gi = 0; gi < LED_W; gi++) begin : g_led
        assign led_next[gi] = (int'(accepted[3:0]) > gi);
    end

    // Display and LED registers, updated together one edge after accepted/mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_reg  <= HEX_OFF;
            ledr_reg <= '0;
        end else begin
            hex_reg  <= hex_next;
            ledr_reg <= led_next;
        end
    end

    assign hex_out = hex_reg;
    assign ledr    = ledr_reg;

endmodule
